fb_write_scheduler: RTL
=======================

Name: fb_write_scheduler

Overview:
- Sequences and arbitrates the single framebuffer write port of the LED matrix display (write_en/write_x/write_y/write_color).
- Serves three sources: an internal full-frame clear engine, the SPI host write stream, and the pattern/physics generator.
- Enforces a minimum spacing between display writes.
- Sits between the SPI/pattern logic and the display instance in the top level.

Parameters:
- COORD_W, 6, width of the x and y coordinates; the frame is 2^COORD_W by 2^COORD_W.
- COLOR_W, 12, pixel colour width ([RRRR,GGGG,BBBB]).
- WRITE_GAP, 16, minimum clk_in cycles between consecutive write_en pulses (>=1; 1 = back-to-back).

Ports:
- clk_in  in  1  system clock (int_osc)
- resetn  in  1  synchronous active-low reset
- clear_req  in  1  single-cycle request to clear the whole frame
- clear_color  in  COLOR_W  fill colour, sampled in the cycle clear_req is accepted
- clear_busy  out  1  high from clear acceptance until the last clear write is issued
- clear_done  out  1  one-cycle pulse in the cycle the last clear write_en is asserted
- host_valid  in  1  SPI host write request
- host_ready  out  1  host request granted this cycle
- host_x, host_y  in  COORD_W  host write coordinates
- host_color  in  COLOR_W  host write colour
- pat_valid  in  1  pattern generator write request
- pat_ready  out  1  pattern request granted this cycle
- pat_x, pat_y  in  COORD_W  pattern write coordinates
- pat_color  in  COLOR_W  pattern write colour
- write_en  out  1  display write strobe (one-cycle pulse)
- write_x, write_y  out  COORD_W  display write coordinates
- write_color  out  COLOR_W  display write colour

Behaviour:
- Reset (resetn low at a clk_in edge): every output is 0, the FSM is in IDLE, the gap counter is 0, clear state is cleared.
- Reset mid-clear aborts the clear. No clear_done is issued.
- The FSM has three states: IDLE, GAP, CLEAR.
- Slot available: the FSM is in IDLE, or it is in CLEAR with the gap counter at 0.
- Transfer: valid && ready at a rising edge.
  - host_ready and pat_ready are combinational, derived from state, the pending clear and the valids.
  - Requesters must not make valid depend on ready.
  - At most one ready is high per cycle.
- Latency: the accepted request appears on write_en/x/y/color exactly 1 cycle after the transfer edge, registered. write_en is high for one cycle.
- Priority in IDLE: clear pending > host > pattern.
  - A clear is accepted when clear_req is high in IDLE or GAP and clear_busy is 0. Acceptance latches clear_color and sets clear_busy.
  - A clear request arriving in the same cycle as host_valid wins; host_ready stays 0.
- GAP: entered after any host or pattern write issue. Both readys are 0. The gap counter loads WRITE_GAP-1 and decrements; the FSM returns to IDLE when the counter reaches 0.
  - With WRITE_GAP=1, GAP is skipped and the next grant can occur the cycle after the previous transfer, giving a write every cycle.
- CLEAR: entered from IDLE when a clear is pending.
  - Issues 2^(2*COORD_W) writes in raster order: x increments fastest (0..max), then y. Every write uses the latched colour.
  - The write spacing is exactly WRITE_GAP cycles. The first write_en is asserted 1 cycle after CLEAR entry.
  - host_ready and pat_ready are held at 0 for the whole CLEAR state.
  - clear_done pulses with the final write at (max, max). clear_busy drops in the same cycle.
  - The FSM then enters GAP, so the next host write is spaced by WRITE_GAP.
- clear_req while clear_busy is 1 is ignored; it is not queued.
- Coordinate counters wrap naturally at COORD_W bits. The end of the clear is detected at x == max && y == max, not by wrap.
- Pattern starvation under a continuous host stream is permitted in fixed-priority mode.
- Outputs hold their last write_x/y/color values when write_en is 0.

Optional Feature:
FBSCHED_RR_EN
- Defined: host and pattern are arbitrated round-robin.
  - A last-grant bit (reset to pattern) gives priority to the requester not granted last.
  - Both valid in consecutive IDLE slots means the grants alternate host, pat, host, ...
  - Clear still has absolute priority.
- Undefined: fixed priority, host over pattern; the last-grant register is not built.

Test Plan:
- Reset then idle: all outputs 0 for 20 cycles with no valids; assert resetn low mid-stream → outputs 0 at the next edge.
- host_valid held with x=5, y=9, color=0xF00 and WRITE_GAP=16 → write_en at cycle T+1 with those values; the next host grant is no sooner than T+16; write_en pulses are exactly 16 cycles apart.
- host_valid and pat_valid held together, fixed priority → 8 consecutive writes, all from host, pat_ready never high; with FBSCHED_RR_EN → sources alternate host, pat, host, pat.
- clear_req with clear_color=0x00F (COORD_W=6, WRITE_GAP=1) → 4096 write_en pulses ordered (0,0),(1,0)…(63,63); clear_busy high throughout; clear_done on the final write; host_valid asserted during the clear is not granted until after it.
- clear_req and host_valid in the same cycle → the clear wins; clear_req again mid-clear is ignored; exactly 4096 writes and a single clear_done.
- resetn low after 100 clear writes → clear_busy=0, no clear_done; a new clear_req restarts from (0,0).

Source files
------------

// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port scheduler: full-frame clear engine, SPI host and pattern sources, minimum write spacing.
// Optional build macro FBSCHED_RR_EN selects round-robin host/pattern arbitration instead of fixed host priority.
module fb_write_scheduler #(
    parameter int COORD_W   = 6,
    parameter int COLOR_W   = 12,
    parameter int WRITE_GAP = 16
) (
    input  logic               clk_in,
    input  logic               resetn,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               clear_busy,
    output logic               clear_done,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic [COORD_W-1:0] host_x,
    input  logic [COORD_W-1:0] host_y,
    input  logic [COLOR_W-1:0] host_color,
    input  logic               pat_valid,
    output logic               pat_ready,
    input  logic [COORD_W-1:0] pat_x,
    input  logic [COORD_W-1:0] pat_y,
    input  logic [COLOR_W-1:0] pat_color,
    output logic               write_en,
    output logic [COORD_W-1:0] write_x,
    output logic [COORD_W-1:0] write_y,
    output logic [COLOR_W-1:0] write_color
);

    localparam int GAP_W = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;
    localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(WRITE_GAP - 1);
    localparam logic [GAP_W-1:0]   GAP_ZERO   = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0]   GAP_ONE    = GAP_W'(1);
    localparam logic [COORD_W-1:0] COORD_ZERO = {COORD_W{1'b0}};
    localparam logic [COORD_W-1:0] COORD_ONE  = COORD_W'(1);
    localparam logic [COORD_W-1:0] COORD_MAX  = {COORD_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t             state_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [COLOR_W-1:0] clear_color_r;
    logic [COORD_W-1:0] clr_x_r;
    logic [COORD_W-1:0] clr_y_r;
    logic               clear_accept_s;
    logic               slot_idle_s;
    logic               last_pixel_s;

`ifdef FBSCHED_RR_EN
    logic last_host_r;
`endif

    // Clear acceptance, free IDLE slot for host/pattern, and end-of-frame detection.
    always_comb begin
        clear_accept_s = resetn && clear_req && !clear_busy &&
                         ((state_r == ST_IDLE) || (state_r == ST_GAP));
        slot_idle_s    = resetn && (state_r == ST_IDLE) && !clear_busy && !clear_accept_s;
        last_pixel_s   = (clr_x_r == COORD_MAX) && (clr_y_r == COORD_MAX);
    end

    // Grant arbitration between host and pattern; a pending clear blocks both.
    always_comb begin
        host_ready = 1'b0;
        pat_ready  = 1'b0;
        if (slot_idle_s) begin
`ifdef FBSCHED_RR_EN
            if (host_valid && (!pat_valid || !last_host_r)) begin
                host_ready = 1'b1;
            end else if (pat_valid) begin
                pat_ready = 1'b1;
            end else begin
                host_ready = 1'b0;
            end
`else
            if (host_valid) begin
                host_ready = 1'b1;
            end else if (pat_valid) begin
                pat_ready = 1'b1;
            end else begin
                pat_ready = 1'b0;
            end
`endif
        end else begin
            host_ready = 1'b0;
            pat_ready  = 1'b0;
        end
    end

`ifdef FBSCHED_RR_EN
    // Remembers which requester won the last slot; resets as if pattern went last.
    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            last_host_r <= 1'b0;
        end else if (host_ready) begin
            last_host_r <= 1'b1;
        end else if (pat_ready) begin
            last_host_r <= 1'b0;
        end
    end
`endif

    // Scheduler FSM with registered write port and clear status outputs.
    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            gap_cnt_r     <= GAP_ZERO;
            clear_busy    <= 1'b0;
            clear_done    <= 1'b0;
            clear_color_r <= {COLOR_W{1'b0}};
            clr_x_r       <= COORD_ZERO;
            clr_y_r       <= COORD_ZERO;
            write_en      <= 1'b0;
            write_x       <= COORD_ZERO;
            write_y       <= COORD_ZERO;
            write_color   <= {COLOR_W{1'b0}};
        end else begin
            write_en   <= 1'b0;
            clear_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (clear_busy || clear_accept_s) begin
                        state_r   <= ST_CLEAR;
                        gap_cnt_r <= GAP_ZERO;
                        clr_x_r   <= COORD_ZERO;
                        clr_y_r   <= COORD_ZERO;
                        if (clear_accept_s) begin
                            clear_busy    <= 1'b1;
                            clear_color_r <= clear_color;
                        end
                    end else if (host_ready || pat_ready) begin
                        write_en    <= 1'b1;
                        write_x     <= host_ready ? host_x : pat_x;
                        write_y     <= host_ready ? host_y : pat_y;
                        write_color <= host_ready ? host_color : pat_color;
                        if (WRITE_GAP > 1) begin
                            state_r   <= ST_GAP;
                            gap_cnt_r <= GAP_LOAD;
                        end
                    end
                end
                ST_GAP: begin
                    // A clear arriving here stays pending until the gap expires.
                    if (clear_accept_s) begin
                        clear_busy    <= 1'b1;
                        clear_color_r <= clear_color;
                    end
                    if (gap_cnt_r <= GAP_ONE) begin
                        state_r   <= ST_IDLE;
                        gap_cnt_r <= GAP_ZERO;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_ONE;
                    end
                end
                ST_CLEAR: begin
                    if (gap_cnt_r == GAP_ZERO) begin
                        write_en    <= 1'b1;
                        write_x     <= clr_x_r;
                        write_y     <= clr_y_r;
                        write_color <= clear_color_r;
                        gap_cnt_r   <= GAP_LOAD;
                        if (last_pixel_s) begin
                            clear_done <= 1'b1;
                            clear_busy <= 1'b0;
                            state_r    <= (WRITE_GAP > 1) ? ST_GAP : ST_IDLE;
                        end else begin
                            clr_x_r <= clr_x_r + COORD_ONE;
                            if (clr_x_r == COORD_MAX) begin
                                clr_y_r <= clr_y_r + COORD_ONE;
                            end
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_ONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    gap_cnt_r  <= GAP_ZERO;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
